// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_unit
// Description : Parametrised program counter with opcode-driven sequencing,
//               PC-relative branch, hardware call/return stack and stall
//               enable. Sits between the control unit (pc_op/pc_en) and the
//               instruction memory (pc_out).
//
// Ports       : clk          rising-edge clock
//               rst          asynchronous active-high reset
//               pc_en        1 = execute pc_op this cycle, 0 = stall
//               pc_op        operation code
//                              000 HOLD, 001 INC, 010 LOAD, 011 BRANCH,
//                              100 CALL, 101 RET, 110 CLEAR, 111 HOLD
//               pc_address   absolute target for LOAD and CALL
//               pc_offset    signed branch offset for BRANCH
//               pc_out       current PC (registered)
//               stack_full   stack holds STACK_DEPTH entries
//               stack_empty  stack holds no entries
//               stack_err    one-cycle pulse on overflow/underflow attempt
//
// Options     : PC_STACK_TRAP_EN - when defined, a stack fault also sends the
//               PC to TRAP_VEC; when undefined the PC holds on a fault.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
    parameter int                 ADDR_W      = 12,
    parameter int                 OFF_W       = 8,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC    = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic [2:0]        pc_op,
    input  logic [ADDR_W-1:0] pc_address,
    input  logic [OFF_W-1:0]  pc_offset,
    output logic [ADDR_W-1:0] pc_out,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;

    localparam logic [2:0] C_OP_HOLD   = 3'b000;
    localparam logic [2:0] C_OP_INC    = 3'b001;
    localparam logic [2:0] C_OP_LOAD   = 3'b010;
    localparam logic [2:0] C_OP_BRANCH = 3'b011;
    localparam logic [2:0] C_OP_CALL   = 3'b100;
    localparam logic [2:0] C_OP_RET    = 3'b101;
    localparam logic [2:0] C_OP_CLEAR  = 3'b110;

    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic              r_full;
    logic              r_empty;
    logic              r_err;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_branch;
    logic [ADDR_W-1:0] w_next_pc;
    logic [SP_W-1:0]   w_next_sp;
    logic [PTR_W-1:0]  w_push_idx;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_push;
    logic              w_fault;

    // Size cast of a signed operand sign-extends the offset to ADDR_W bits;
    // the add then wraps modulo 2^ADDR_W in both directions.
    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_pc_branch = r_pc + ADDR_W'($signed(pc_offset));

    // Only meaningful when the stack is not full (push) or not empty (pop),
    // so truncating sp to the RAM index width is safe.
    assign w_push_idx  = r_sp[PTR_W-1:0];
    assign w_top_idx   = r_sp[PTR_W-1:0] - PTR_W'(1);

    always_comb begin
        w_next_pc = r_pc;
        w_next_sp = r_sp;
        w_push    = 1'b0;
        w_fault   = 1'b0;
        case (pc_op)
            C_OP_HOLD:   w_next_pc = r_pc;
            C_OP_INC:    w_next_pc = w_pc_inc;
            C_OP_LOAD:   w_next_pc = pc_address;
            C_OP_BRANCH: w_next_pc = w_pc_branch;
            C_OP_CALL: begin
                if (r_full) begin
                    w_fault = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_next_sp = r_sp + SP_W'(1);
                    w_next_pc = pc_address;
                end
            end
            C_OP_RET: begin
                if (r_empty) begin
                    w_fault = 1'b1;
                end else begin
                    w_next_sp = r_sp - SP_W'(1);
                    w_next_pc = r_stack[w_top_idx];
                end
            end
            C_OP_CLEAR: begin
                w_next_pc = RESET_VEC;
                w_next_sp = '0;
            end
            default:     w_next_pc = r_pc;
        endcase
`ifdef PC_STACK_TRAP_EN
        if (w_fault) begin
            w_next_pc = TRAP_VEC;
        end
`endif
    end

`ifndef PC_STACK_TRAP_EN
    // TRAP_VEC has no function without the trap option.
    logic w_unused_trap;
    assign w_unused_trap = ^TRAP_VEC;
`endif

    // Flags are computed from the next sp so they are registered alongside
    // sp and always agree with it after each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_VEC;
            r_sp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_err   <= 1'b0;
        end else if (pc_en) begin
            r_pc    <= w_next_pc;
            r_sp    <= w_next_sp;
            r_full  <= (w_next_sp == SP_W'(STACK_DEPTH));
            r_empty <= (w_next_sp == '0);
            r_err   <= w_fault;
        end else begin
            r_err   <= 1'b0;
        end
    end

    // Stack RAM carries no reset; a write coinciding with reset is suppressed
    // so an aborted CALL leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst && pc_en && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc_out      = r_pc;
    assign stack_full  = r_full;
    assign stack_empty = r_empty;
    assign stack_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stack_unit
// Description : Self-checking bench for pc_stack_unit. A behavioural model
//               predicts each cycle's outputs, which are queued on drive and
//               popped/compared after the clock edge. Directed sequences
//               follow the test plan, then a random op mix runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stack_unit;

    localparam int         ADDR_W    = 12;
    localparam int         OFF_W     = 8;
    localparam int         DEPTH     = 8;
    localparam logic [11:0] RST_V    = 12'h000;
    localparam logic [11:0] TRAP_V   = 12'hFFF;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, LOAD = 3'd2, BRANCH = 3'd3,
                           CALL = 3'd4, RET = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              pc_en;
    logic [2:0]        pc_op;
    logic [ADDR_W-1:0] pc_address;
    logic [OFF_W-1:0]  pc_offset;
    logic [ADDR_W-1:0] pc_out;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    pc_stack_unit #(
        .ADDR_W      (ADDR_W),
        .OFF_W       (OFF_W),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (RST_V),
        .TRAP_VEC    (TRAP_V)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en       (pc_en),
        .pc_op       (pc_op),
        .pc_address  (pc_address),
        .pc_offset   (pc_offset),
        .pc_out      (pc_out),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] pc;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] m_pc;
    logic [11:0] m_stack[$];
    logic        m_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_V;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [2:0] op,
                              input logic [11:0] addr, input logic [7:0] off);
        logic fault;
        fault = 1'b0;
        if (!en) begin
            m_err = 1'b0;
            return;
        end
        case (op)
            INC:    m_pc = m_pc + 12'd1;
            LOAD:   m_pc = addr;
            BRANCH: m_pc = m_pc + {{4{off[7]}}, off};
            CALL: begin
                if (m_stack.size() == DEPTH) fault = 1'b1;
                else begin
                    m_stack.push_back(m_pc + 12'd1);
                    m_pc = addr;
                end
            end
            RET: begin
                if (m_stack.size() == 0) fault = 1'b1;
                else m_pc = m_stack.pop_back();
            end
            CLEAR: begin
                m_pc = RST_V;
                m_stack.delete();
            end
            default: ;
        endcase
`ifdef PC_STACK_TRAP_EN
        if (fault) m_pc = TRAP_V;
`endif
        m_err = fault;
    endtask

    // Drive one op, queue the predicted result, clock, then compare.
    task automatic step(input logic en, input logic [2:0] op,
                        input logic [11:0] addr = 12'h000, input logic [7:0] off = 8'h00);
        exp_t e;
        exp_t got;
        pc_en      = en;
        pc_op      = op;
        pc_address = addr;
        pc_offset  = off;
        model_step(en, op, addr, off);
        e.pc    = m_pc;
        e.full  = (m_stack.size() == DEPTH);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            got = {pc_out, stack_full, stack_empty, stack_err};
            check("pc_out", 32'(got.pc), 32'(e.pc));
            check("stack_full", 32'(got.full), 32'(e.full));
            check("stack_empty", 32'(got.empty), 32'(e.empty));
            check("stack_err", 32'(got.err), 32'(e.err));
        end
    endtask

    initial begin
        rst = 1'b1;
        pc_en = 1'b0;
        pc_op = HOLD;
        pc_address = '0;
        pc_offset = '0;
        model_reset();
        #3;
        check("rst_pc", 32'(pc_out), 32'(RST_V));
        check("rst_empty", 32'(stack_empty), 32'd1);
        check("rst_full", 32'(stack_full), 32'd0);
        check("rst_err", 32'(stack_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Count to 5, then assert reset asynchronously with a CALL pending.
        repeat (5) step(1'b1, INC);
        check("pc_at_5", 32'(pc_out), 32'h005);
        pc_op = CALL;
        pc_address = 12'h123;
        pc_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", 32'(pc_out), 32'h000);
        @(posedge clk);
        #1;
        check("rst_abort_empty", 32'(stack_empty), 32'd1);
        check("rst_abort_pc", 32'(pc_out), 32'h000);
        rst = 1'b0;
        model_reset();

        repeat (3) step(1'b1, INC);
        check("three_inc", 32'(pc_out), 32'h003);
        step(1'b1, LOAD, 12'hFFF);
        step(1'b1, INC);
        check("inc_wrap", 32'(pc_out), 32'h000);

        // Branch both directions with wrap.
        step(1'b1, LOAD, 12'h010);
        step(1'b1, BRANCH, 12'h000, 8'hF0);
        check("br_neg16", 32'(pc_out), 32'h000);
        step(1'b1, BRANCH, 12'h000, 8'hFF);
        check("br_wrap_neg", 32'(pc_out), 32'hFFF);
        step(1'b1, BRANCH, 12'h000, 8'h7F);
        check("br_wrap_pos", 32'(pc_out), 32'h07E);

        // Nested call/return with back-to-back CALL->RET.
        step(1'b1, LOAD, 12'h020);
        step(1'b1, CALL, 12'h100);
        check("call1", 32'(pc_out), 32'h100);
        step(1'b1, CALL, 12'h200);
        check("call2", 32'(pc_out), 32'h200);
        step(1'b1, RET);
        check("ret1", 32'(pc_out), 32'h101);
        step(1'b1, RET);
        check("ret2", 32'(pc_out), 32'h021);
        check("nest_empty", 32'(stack_empty), 32'd1);

        // Overflow then LIFO unwind.
        for (int i = 0; i < DEPTH; i++) step(1'b1, CALL, 12'h400 + 12'(i));
        check("ovf_full", 32'(stack_full), 32'd1);
        step(1'b1, CALL, 12'h300);
        check("ovf_err", 32'(stack_err), 32'd1);
`ifdef PC_STACK_TRAP_EN
        check("ovf_pc", 32'(pc_out), 32'hFFF);
`else
        check("ovf_pc", 32'(pc_out), 32'h407);
`endif
        check("ovf_still_full", 32'(stack_full), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, RET);
        check("unwind_pc", 32'(pc_out), 32'h022);
        check("unwind_empty", 32'(stack_empty), 32'd1);

        // Underflow, then a four-cycle stall.
        step(1'b1, RET);
        check("udf_err", 32'(stack_err), 32'd1);
        repeat (4) step(1'b0, INC);
        check("stall_err", 32'(stack_err), 32'd0);

        // Soft clear empties the stack; next RET underflows.
        step(1'b1, LOAD, 12'h055);
        repeat (3) step(1'b1, CALL, 12'h600);
        step(1'b1, CLEAR);
        check("clear_pc", 32'(pc_out), 32'(RST_V));
        check("clear_empty", 32'(stack_empty), 32'd1);
        step(1'b1, RET);
        check("clear_udf", 32'(stack_err), 32'd1);

        // Random mix including reserved op and stalls.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                 12'($urandom), 8'($urandom));
        end
        step(1'b1, RSVD);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
